// File: rtl/mips_jb_pkg.sv
// Shared types and constants for the D-stage jump/branch resolution logic.
// Contents: jr_state_t (stall-wait FSM states), REG_ZERO / REG_RA register indices.
package mips_jb_pkg;

  typedef enum logic [0:0] {
    JR_IDLE = 1'b0,
    JR_WAIT = 1'b1
  } jr_state_t;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_RA   = 31;

endpackage

// File: rtl/jr_ras.sv
// Return-address stack: circular buffer with write pointer and occupancy count.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   push, pushData     : push request and link address
//   pop                : pop request (ignored when empty)
//   target             : resolved jump target, compared against the top entry on pop
//   rasValid, rasPred  : stack non-empty, top-of-stack value (combinational)
//   rasMiss            : registered; top entry differed from target on the last pop
module jr_ras #(
  parameter int unsigned DW        = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] pushData,
  input  logic          pop,
  input  logic [DW-1:0] target,
  output logic          rasValid,
  output logic [DW-1:0] rasPred,
  output logic          rasMiss
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned OCC_W = $clog2(RAS_DEPTH + 1);

  logic [DW-1:0]    stack [RAS_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [OCC_W-1:0] count;
  logic [PTR_W-1:0] topIdx;
  logic [PTR_W-1:0] ptrAfterPop;
  logic [OCC_W-1:0] cntAfterPop;
  logic             doPop;

  // Top-of-stack view and the pop-first intermediate pointer/count.
  always_comb begin
    topIdx      = wrPtr - PTR_W'(1);
    rasValid    = (count != '0);
    rasPred     = rasValid ? stack[topIdx] : '0;
    doPop       = pop && rasValid;
    ptrAfterPop = doPop ? topIdx : wrPtr;
    cntAfterPop = doPop ? (count - OCC_W'(1)) : count;
  end

  // Pointer/count update; a push when full lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr   <= '0;
      count   <= '0;
      rasMiss <= 1'b0;
    end else begin
      rasMiss <= doPop && (rasPred != target);
      if (push) begin
        wrPtr <= ptrAfterPop + PTR_W'(1);
        count <= (cntAfterPop == OCC_W'(RAS_DEPTH)) ? cntAfterPop : (cntAfterPop + OCC_W'(1));
      end else begin
        wrPtr <= ptrAfterPop;
        count <= cntAfterPop;
      end
    end
  end

  // Storage needs no reset: reads are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      stack[ptrAfterPop] <= pushData;
    end
  end

endmodule

// File: rtl/jr_resolve_unit.sv
// D-stage register-jump resolution: forwards the jr/jalr source from E/M/W,
// stalls D while the operand is not yet available, tracks stall time with a
// watchdog and a saturating counter. Optional return-address stack under
// macro JR_RAS_EN (disabled: ras_* outputs tied to 0).
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   flush_d, jr_d, link_d           : D-stage kill, jr/jalr, jal/jalr
//   link_addr_d, rs_d, rdata1       : link address, jump source reg, RF read
//   *_e / *_m / *_w                 : writer info from E, M and W
//   jump_reg, npc_target, stall_d   : combinational redirect / target / stall
//   waiting, hang_err, stall_cnt    : FSM in WAIT, sticky watchdog, stall count
//   ras_valid, ras_pred, ras_miss   : return-address prediction
module jr_resolve_unit
  import mips_jb_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned RW        = 5,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned MAX_WAIT  = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_d,
  input  logic             jr_d,
  input  logic             link_d,
  input  logic [DW-1:0]    link_addr_d,
  input  logic [RW-1:0]    rs_d,
  input  logic [DW-1:0]    rdata1,
  input  logic             regwrite_e,
  input  logic             ready_e,
  input  logic [RW-1:0]    rd_e,
  input  logic [DW-1:0]    result_e,
  input  logic             regwrite_m,
  input  logic             memtoreg_m,
  input  logic [RW-1:0]    rd_m,
  input  logic [DW-1:0]    result_m,
  input  logic             regwrite_w,
  input  logic [RW-1:0]    rd_w,
  input  logic [DW-1:0]    wdata_w,
  output logic             jump_reg,
  output logic [DW-1:0]    npc_target,
  output logic             stall_d,
  output logic             waiting,
  output logic             hang_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             ras_valid,
  output logic [DW-1:0]    ras_pred,
  output logic             ras_miss
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  jr_state_t         state;
  jr_state_t         stateNext;
  logic [WAIT_W-1:0] waitCnt;
  logic              rsZero;
  logic              eMatch;
  logic              mMatch;
  logic              wMatch;
  logic              hazard;

  // Operand forwarding (E > M > W > RF) and hazard detection.
  always_comb begin
    rsZero = (rs_d == RW'(REG_ZERO));
    eMatch = regwrite_e && (rd_e == rs_d) && !rsZero;
    mMatch = regwrite_m && (rd_m == rs_d) && !rsZero;
    wMatch = regwrite_w && (rd_w == rs_d) && !rsZero;
    // An unready E writer shadows everything older; a load in M is only
    // shadowed by a ready E writer of the same register.
    hazard = jr_d && ((eMatch && !ready_e) || (!eMatch && mMatch && memtoreg_m));
    if (rsZero) begin
      npc_target = '0;
    end else if (eMatch && ready_e) begin
      npc_target = result_e;
    end else if (mMatch) begin
      npc_target = result_m;
    end else if (wMatch) begin
      npc_target = wdata_w;
    end else begin
      npc_target = rdata1;
    end
  end

  assign stall_d  = hazard;
  assign jump_reg = jr_d && !hazard && !flush_d;
  assign waiting  = (state == JR_WAIT);

  // Stall-wait FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= JR_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Stall-wait FSM next state; a flush always abandons the wait.
  always_comb begin
    stateNext = state;
    case (state)
      JR_IDLE: if (hazard && !flush_d) stateNext = JR_WAIT;
      JR_WAIT: if (!hazard || flush_d) stateNext = JR_IDLE;
      default: stateNext = JR_IDLE;
    endcase
  end

  // Watchdog and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCnt   <= '0;
      hang_err  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (state == JR_WAIT) begin
        if (waitCnt != WAIT_W'(MAX_WAIT)) begin
          waitCnt <= waitCnt + WAIT_W'(1);
        end
        if (waitCnt == WAIT_W'(MAX_WAIT - 1)) begin
          hang_err <= 1'b1;
        end
      end else begin
        waitCnt <= '0;
      end
      if (stall_d && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

`ifdef JR_RAS_EN
  logic rasPush;
  logic rasPop;

  always_comb begin
    rasPush = link_d && !stall_d && !flush_d;
    rasPop  = jump_reg && (rs_d == RW'(REG_RA));
  end

  jr_ras #(
    .DW       (DW),
    .RAS_DEPTH(RAS_DEPTH)
  ) uRas (
    .clk     (clk),
    .reset   (reset),
    .push    (rasPush),
    .pushData(link_addr_d),
    .pop     (rasPop),
    .target  (npc_target),
    .rasValid(ras_valid),
    .rasPred (ras_pred),
    .rasMiss (ras_miss)
  );
`else
  logic unusedRas;

  assign ras_valid = 1'b0;
  assign ras_pred  = '0;
  assign ras_miss  = 1'b0;
  assign unusedRas = ^{link_d, link_addr_d};
`endif

endmodule

// File: tb/tb_jr_resolve_unit.sv
// Self-checking bench for jr_resolve_unit: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_jr_resolve_unit;

  localparam int DW        = 32;
  localparam int RW        = 5;
  localparam int RAS_DEPTH = 4;
  localparam int MAX_WAIT  = 3;
  localparam int CNT_W     = 16;
`ifdef JR_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  typedef struct {
    logic        rst, flush, jr, link;
    logic [31:0] linkAddr;
    logic [4:0]  rs;
    logic [31:0] rdata1;
    logic        rwE, rdyE;
    logic [4:0]  rdE;
    logic [31:0] resE;
    logic        rwM, m2r;
    logic [4:0]  rdM;
    logic [31:0] resM;
    logic        rwW;
    logic [4:0]  rdW;
    logic [31:0] wdW;
  } in_t;

  typedef struct {
    in_t         in;
    logic        expStall;
    logic        expJump;
    logic [31:0] expTgt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t cur;

  logic             reset, flush_d, jr_d, link_d;
  logic [DW-1:0]    link_addr_d, rdata1, result_e, result_m, wdata_w;
  logic [RW-1:0]    rs_d, rd_e, rd_m, rd_w;
  logic             regwrite_e, ready_e, regwrite_m, memtoreg_m, regwrite_w;
  logic             jump_reg, stall_d, waiting, hang_err, ras_valid, ras_miss;
  logic [DW-1:0]    npc_target, ras_pred;
  logic [CNT_W-1:0] stall_cnt;

  assign reset       = cur.rst;
  assign flush_d     = cur.flush;
  assign jr_d        = cur.jr;
  assign link_d      = cur.link;
  assign link_addr_d = cur.linkAddr;
  assign rs_d        = cur.rs;
  assign rdata1      = cur.rdata1;
  assign regwrite_e  = cur.rwE;
  assign ready_e     = cur.rdyE;
  assign rd_e        = cur.rdE;
  assign result_e    = cur.resE;
  assign regwrite_m  = cur.rwM;
  assign memtoreg_m  = cur.m2r;
  assign rd_m        = cur.rdM;
  assign result_m    = cur.resM;
  assign regwrite_w  = cur.rwW;
  assign rd_w        = cur.rdW;
  assign wdata_w     = cur.wdW;

  jr_resolve_unit #(
    .DW(DW), .RW(RW), .RAS_DEPTH(RAS_DEPTH), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush_d(flush_d), .jr_d(jr_d), .link_d(link_d),
    .link_addr_d(link_addr_d), .rs_d(rs_d), .rdata1(rdata1),
    .regwrite_e(regwrite_e), .ready_e(ready_e), .rd_e(rd_e), .result_e(result_e),
    .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .rd_m(rd_m), .result_m(result_m),
    .regwrite_w(regwrite_w), .rd_w(rd_w), .wdata_w(wdata_w),
    .jump_reg(jump_reg), .npc_target(npc_target), .stall_d(stall_d),
    .waiting(waiting), .hang_err(hang_err), .stall_cnt(stall_cnt),
    .ras_valid(ras_valid), .ras_pred(ras_pred), .ras_miss(ras_miss)
  );

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // Reference model state.
  bit          mWait;
  int          mRun;
  bit          mHang;
  longint      mStall;
  bit          mMiss;
  logic [31:0] mRas[$];
  logic        eHz, eJmp;
  logic [31:0] eTgt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, name, act, exp, $time);
    end
  endtask

  function automatic in_t zin();
    in_t v;
    v.rst = 0; v.flush = 0; v.jr = 0; v.link = 0; v.linkAddr = 0; v.rs = 0; v.rdata1 = 0;
    v.rwE = 0; v.rdyE = 0; v.rdE = 0; v.resE = 0;
    v.rwM = 0; v.m2r = 0; v.rdM = 0; v.resM = 0;
    v.rwW = 0; v.rdW = 0; v.wdW = 0;
    return v;
  endfunction

  // First writer (youngest first) of rs decides: it either supplies the value or blocks.
  function automatic void model_comb(input in_t v, output logic hz, output logic [31:0] tgt);
    logic        wr[3];
    logic [4:0]  rd[3];
    logic        blk[3];
    logic [31:0] val[3];
    wr  = '{v.rwE, v.rwM, v.rwW};
    rd  = '{v.rdE, v.rdM, v.rdW};
    blk = '{!v.rdyE, v.m2r, 1'b0};
    val = '{v.resE, v.resM, v.wdW};
    hz  = 1'b0;
    tgt = v.rdata1;
    if (v.rs == 5'd0) begin
      tgt = 32'd0;
      return;
    end
    for (int s = 0; s < 3; s++) begin
      if (wr[s] && rd[s] == v.rs) begin
        hz  = v.jr && blk[s];
        tgt = val[s];
        return;
      end
    end
  endfunction

  function automatic void model_reset();
    mWait = 0; mRun = 0; mHang = 0; mStall = 0; mMiss = 0;
    mRas.delete();
  endfunction

  function automatic void model_edge();
    bit pop;
    if (cur.rst) begin
      model_reset();
      return;
    end
    if (mWait) begin
      mRun++;
      if (mRun >= MAX_WAIT) mHang = 1;
    end else begin
      mRun = 0;
    end
    if (eHz && mStall < (64'd1 << CNT_W) - 1) mStall++;
    mWait = eHz && !cur.flush;
    if (RAS_ON) begin
      pop   = eJmp && cur.rs == 5'd31;
      mMiss = pop && mRas.size() > 0 && mRas[$] != eTgt;
      if (pop && mRas.size() > 0) void'(mRas.pop_back());
      if (cur.link && !eHz && !cur.flush) begin
        mRas.push_back(cur.linkAddr);
        if (mRas.size() > RAS_DEPTH) void'(mRas.pop_front());
      end
    end
  endfunction

  task automatic cyc_begin();
    #1;
    model_comb(cur, eHz, eTgt);
    eJmp = cur.jr && !eHz && !cur.flush;
    chk("stall_d", stall_d, eHz);
    chk("jump_reg", jump_reg, eJmp);
    if (eJmp) chk("npc_target", npc_target, eTgt);
    chk("waiting", waiting, mWait);
    chk("hang_err", hang_err, mHang);
    chk("stall_cnt", stall_cnt, mStall);
    chk("ras_valid", ras_valid, mRas.size() > 0);
    chk("ras_pred", ras_pred, (mRas.size() > 0) ? mRas[$] : 32'd0);
    chk("ras_miss", ras_miss, mMiss);
  endtask

  task automatic cyc_end();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc();
    cyc_begin();
    cyc_end();
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      3: return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic do_reset();
    cur = zin();
    cur.rst = 1;
    cyc();
    cur = zin();
  endtask

  vec_t tv[9];

  initial begin
    // Fill the directed vector table (jr_d = 1 unless noted).
    for (int i = 0; i < 9; i++) begin
      tv[i].in = zin();
      tv[i].in.jr = 1;
      tv[i].expStall = 0;
      tv[i].expJump = 1;
      tv[i].expTgt = 0;
    end
    // M match, ALU result.
    tv[0].in.rs = 8; tv[0].in.rwM = 1; tv[0].in.rdM = 8; tv[0].in.resM = 32'h0040_0100;
    tv[0].expTgt = 32'h0040_0100;
    // E beats W.
    tv[1].in.rs = 9; tv[1].in.rwE = 1; tv[1].in.rdyE = 1; tv[1].in.rdE = 9; tv[1].in.resE = 32'h10;
    tv[1].in.rwW = 1; tv[1].in.rdW = 9; tv[1].in.wdW = 32'h99;
    tv[1].expTgt = 32'h10;
    // $0 always yields 0.
    tv[2].in.rs = 0; tv[2].in.rwE = 1; tv[2].in.rdyE = 1; tv[2].in.resE = 32'h11;
    tv[2].in.rwM = 1; tv[2].in.resM = 32'h22; tv[2].in.rwW = 1; tv[2].in.wdW = 32'h33;
    tv[2].in.rdata1 = 32'hdead;
    tv[2].expTgt = 0;
    // No writer matches: register file.
    tv[3].in.rs = 5; tv[3].in.rwE = 1; tv[3].in.rdyE = 1; tv[3].in.rdE = 6; tv[3].in.resE = 32'h66;
    tv[3].in.rdata1 = 32'habc;
    tv[3].expTgt = 32'habc;
    // M beats W.
    tv[4].in.rs = 7; tv[4].in.rwM = 1; tv[4].in.rdM = 7; tv[4].in.resM = 32'h70;
    tv[4].in.rwW = 1; tv[4].in.rdW = 7; tv[4].in.wdW = 32'h77;
    tv[4].expTgt = 32'h70;
    // E writer not ready: hazard.
    tv[5].in.rs = 10; tv[5].in.rwE = 1; tv[5].in.rdE = 10; tv[5].in.rdata1 = 32'h5;
    tv[5].expStall = 1; tv[5].expJump = 0;
    // Ready E shadows a load in M.
    tv[6].in.rs = 11; tv[6].in.rwE = 1; tv[6].in.rdyE = 1; tv[6].in.rdE = 11; tv[6].in.resE = 32'hE0;
    tv[6].in.rwM = 1; tv[6].in.m2r = 1; tv[6].in.rdM = 11; tv[6].in.resM = 32'hB0;
    tv[6].expTgt = 32'hE0;
    // E not writing: unready flag ignored, W supplies.
    tv[7].in.rs = 11; tv[7].in.rdE = 11; tv[7].in.rwW = 1; tv[7].in.rdW = 11; tv[7].in.wdW = 32'h11;
    tv[7].expTgt = 32'h11;
    // Load-use pattern without a jump: no stall.
    tv[8].in.jr = 0; tv[8].in.rs = 31; tv[8].in.rwM = 1; tv[8].in.m2r = 1; tv[8].in.rdM = 31;
    tv[8].expJump = 0;

    // Reset.
    cur = zin();
    cur.rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cur = zin();
    phase = "reset";
    cyc_begin();
    chk("rst_waiting", waiting, 0);
    chk("rst_hang", hang_err, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_ras_valid", ras_valid, 0);
    chk("rst_ras_pred", ras_pred, 0);
    chk("rst_ras_miss", ras_miss, 0);
    cyc_end();

    // Load-use on $31, then value arrives from W.
    phase = "loaduse";
    cur.jr = 1; cur.rs = 31; cur.rwM = 1; cur.m2r = 1; cur.rdM = 31; cur.resM = 32'hdeadbeef;
    cyc_begin();
    chk("lu_stall", stall_d, 1);
    chk("lu_jump", jump_reg, 0);
    cyc_end();
    cur.rwM = 0; cur.m2r = 0; cur.rwW = 1; cur.rdW = 31; cur.wdW = 32'h0040_0200;
    cyc_begin();
    chk("lu_waiting", waiting, 1);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_jump", jump_reg, 1);
    chk("lu_target", npc_target, 32'h0040_0200);
    chk("lu_stall_clear", stall_d, 0);
    cyc_end();
    cur = zin();
    cyc_begin();
    chk("lu_idle", waiting, 0);
    cyc_end();

    // Directed table.
    phase = "table";
    for (int i = 0; i < 9; i++) begin
      cur = tv[i].in;
      cyc_begin();
      chk($sformatf("tv%0d_stall", i), stall_d, tv[i].expStall);
      chk($sformatf("tv%0d_jump", i), jump_reg, tv[i].expJump);
      if (tv[i].expJump) chk($sformatf("tv%0d_target", i), npc_target, tv[i].expTgt);
      cyc_end();
    end
    cur = zin();
    cyc();

    // Watchdog: four cycles of unready E writer.
    phase = "watchdog";
    do_reset();
    cur.jr = 1; cur.rs = 12; cur.rwE = 1; cur.rdE = 12; cur.rdyE = 0;
    for (int k = 0; k < 4; k++) begin
      cyc_begin();
      if (k == 3) chk("wd_hang_before", hang_err, 0);
      cyc_end();
    end
    cur.rdyE = 1; cur.resE = 32'h0040_0300;
    cyc_begin();
    chk("wd_hang_set", hang_err, 1);
    chk("wd_jump", jump_reg, 1);
    chk("wd_target", npc_target, 32'h0040_0300);
    cyc_end();
    cur = zin();
    cyc_begin();
    chk("wd_hang_sticky", hang_err, 1);
    chk("wd_idle", waiting, 0);
    cyc_end();
    do_reset();
    cyc_begin();
    chk("wd_rst_hang", hang_err, 0);
    chk("wd_rst_stall_cnt", stall_cnt, 0);
    chk("wd_rst_waiting", waiting, 0);
    cyc_end();

    // Flush mid-wait.
    phase = "flush";
    cur.jr = 1; cur.rs = 12; cur.rwE = 1; cur.rdE = 12; cur.rdyE = 0;
    cyc();
    cyc();
    cur.flush = 1;
    cyc_begin();
    chk("fl_jump", jump_reg, 0);
    chk("fl_stall", stall_d, 1);
    chk("fl_waiting", waiting, 1);
    cyc_end();
    cur = zin();
    cyc_begin();
    chk("fl_idle", waiting, 0);
    chk("fl_stall_cnt", stall_cnt, 3);
    cyc_end();

    // Reset mid-wait.
    phase = "rstwait";
    cur.jr = 1; cur.rs = 12; cur.rwE = 1; cur.rdE = 12; cur.rdyE = 0;
    cyc();
    cyc();
    cur.rst = 1;
    cyc();
    cur = zin();
    cyc_begin();
    chk("rw_waiting", waiting, 0);
    chk("rw_stall_cnt", stall_cnt, 0);
    chk("rw_jump", jump_reg, 0);
    cyc_end();

    // Return-address stack.
    phase = "ras";
    do_reset();
`ifdef JR_RAS_EN
    for (int k = 1; k <= 5; k++) begin
      cur = zin(); cur.link = 1; cur.linkAddr = 32'(k * 32'h100);
      cyc();
    end
    for (int k = 0; k < 5; k++) begin
      cur = zin(); cur.jr = 1; cur.rs = 31;
      cur.rdata1 = (k < 4) ? 32'((5 - k) * 32'h100) : 32'd0;
      cyc_begin();
      if (k < 4) begin
        chk($sformatf("ras_valid%0d", k), ras_valid, 1);
        chk($sformatf("ras_pred%0d", k), ras_pred, 32'((5 - k) * 32'h100));
      end else begin
        chk("ras_empty", ras_valid, 0);
      end
      cyc_end();
    end
    cur = zin(); cur.link = 1; cur.linkAddr = 32'h500;
    cyc();
    cur = zin(); cur.jr = 1; cur.rs = 31; cur.rdata1 = 32'h504;
    cyc_begin();
    chk("ras_top", ras_pred, 32'h500);
    cyc_end();
    cur = zin();
    cyc_begin();
    chk("ras_miss_set", ras_miss, 1);
    cyc_end();
    cyc_begin();
    chk("ras_miss_clear", ras_miss, 0);
    cyc_end();
`else
    cur = zin(); cur.link = 1; cur.linkAddr = 32'h100;
    cyc();
    cur = zin();
    cyc_begin();
    chk("ras_off_valid", ras_valid, 0);
    chk("ras_off_pred", ras_pred, 0);
    cyc_end();
`endif

    // Randomized traffic against the model.
    phase = "random";
    for (int n = 0; n < 600; n++) begin
      cur = zin();
      cur.rst      = ($urandom_range(0, 59) == 0);
      cur.flush    = ($urandom_range(0, 7) == 0);
      cur.jr       = 1'($urandom_range(0, 1));
      cur.link     = ($urandom_range(0, 3) == 0);
      cur.linkAddr = $urandom;
      cur.rs       = pick_reg();
      cur.rdata1   = (mRas.size() > 0 && $urandom_range(0, 1) == 1) ? mRas[$] : $urandom;
      cur.rwE      = 1'($urandom_range(0, 1));
      cur.rdyE     = ($urandom_range(0, 3) != 0);
      cur.rdE      = pick_reg();
      cur.resE     = $urandom;
      cur.rwM      = 1'($urandom_range(0, 1));
      cur.m2r      = ($urandom_range(0, 2) == 0);
      cur.rdM      = pick_reg();
      cur.resM     = $urandom;
      cur.rwW      = 1'($urandom_range(0, 1));
      cur.rdW      = pick_reg();
      cur.wdW      = $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
